// File: rtl/mult_sched_pkg.sv
// Shared widths, issue-mode encoding and lane helpers for the packing multiplier scheduler.
package mult_sched_pkg;

    localparam int LANE_W = 8;
    localparam int HALF_W = 4;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_FULL = 2'd1,
        MODE_HALF = 2'd2
    } mode_e;

    // Widen an 8-bit lane product to the result width, honouring operand signedness.
    function automatic logic [PROD_W-1:0] ext_lane(input logic [LANE_W-1:0] p, input logic s);
        return {{(PROD_W-LANE_W){s & p[LANE_W-1]}}, p};
    endfunction

endpackage

// File: rtl/mult_pack_scheduler_mult.sv
// Precision-configurable multiplier: one 8x8 product, or two independent 4x4 lane products.
module multiplier_S_C2x2_F1_8bits_8bits_HighLevelDescribed_auto
    import mult_sched_pkg::*;
(
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic              i_a_sign,
    input  logic              i_b_sign,
    input  logic              i_half_0,
    input  logic              i_half_1,
    output logic [PROD_W-1:0] o_c
);

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_full_p;
    logic [LANE_W-1:0] w_lane_p [2];
    logic              w_dual;

    assign w_dual   = i_half_1 && !i_half_0;
    assign w_a_ext  = {{(PROD_W-LANE_W){i_a_sign & i_a[LANE_W-1]}}, i_a};
    assign w_b_ext  = {{(PROD_W-LANE_W){i_b_sign & i_b[LANE_W-1]}}, i_b};
    // Low 16 bits of the extended product are exact for both signed and unsigned operands.
    assign w_full_p = w_a_ext * w_b_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [HALF_W-1:0] w_na;
            logic [HALF_W-1:0] w_nb;
            logic [LANE_W-1:0] w_na_ext;
            logic [LANE_W-1:0] w_nb_ext;

            assign w_na          = i_a[gi*HALF_W +: HALF_W];
            assign w_nb          = i_b[gi*HALF_W +: HALF_W];
            assign w_na_ext      = {{(LANE_W-HALF_W){i_a_sign & w_na[HALF_W-1]}}, w_na};
            assign w_nb_ext      = {{(LANE_W-HALF_W){i_b_sign & w_nb[HALF_W-1]}}, w_nb};
            assign w_lane_p[gi]  = w_na_ext * w_nb_ext;
        end
    endgenerate

    assign o_c = w_dual ? {w_lane_p[1], w_lane_p[0]} : w_full_p;

endmodule

// File: rtl/mult_pack_scheduler.sv
// Two-requester scheduler for a shared multiplier; packs compatible 4x4 requests into both lanes.
module mult_pack_scheduler
    import mult_sched_pkg::*;
#(
    parameter logic PACK_DEFAULT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pack_en_ovr,
    input  logic              pack_en,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [LANE_W-1:0] req0_a,
    input  logic [LANE_W-1:0] req0_b,
    input  logic              req0_signed,
    input  logic              req0_half,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [LANE_W-1:0] req1_a,
    input  logic [LANE_W-1:0] req1_b,
    input  logic              req1_signed,
    input  logic              req1_half,
    output logic              res0_valid,
    input  logic              res0_ready,
    output logic [PROD_W-1:0] res0_c,
    output logic              res1_valid,
    input  logic              res1_ready,
    output logic [PROD_W-1:0] res1_c,
    output logic [CNT_W-1:0]  pack_cnt
);

    logic [1:0]        w_req_valid;
    logic [1:0]        w_req_signed;
    logic [1:0]        w_req_half;
    logic [1:0]        w_res_ready;
    logic [1:0]        w_res_valid;
    logic [1:0]        w_elig;
    logic [1:0]        w_grant;
    logic [LANE_W-1:0] w_req_a [2];
    logic [LANE_W-1:0] w_req_b [2];
    logic [PROD_W-1:0] w_res_q [2];
    logic              w_pack_en;
    logic              w_pack;
    logic              w_sel;
    mode_e             w_issue_mode;

    logic [LANE_W-1:0] w_mul_a;
    logic [LANE_W-1:0] w_mul_b;
    logic              w_mul_a_sign;
    logic              w_mul_b_sign;
    logic              w_half_0;
    logic              w_half_1;
    logic [PROD_W-1:0] w_mul_c;

    logic              r_ptr;
    logic [CNT_W-1:0]  r_pack_cnt;

    assign w_req_valid  = {req1_valid, req0_valid};
    assign w_req_signed = {req1_signed, req0_signed};
    assign w_req_half   = {req1_half, req0_half};
    assign w_res_ready  = {res1_ready, res0_ready};
    assign w_req_a[0]   = req0_a;
    assign w_req_a[1]   = req1_a;
    assign w_req_b[0]   = req0_b;
    assign w_req_b[1]   = req1_b;
    assign w_pack_en    = pack_en_ovr ? pack_en : PACK_DEFAULT;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            // A requester may issue only if its result slot is empty or draining this cycle.
            assign w_elig[gi] = rst_n && w_req_valid[gi] && (!w_res_valid[gi] || w_res_ready[gi]);
        end
    endgenerate

    always_comb begin
        w_pack  = w_pack_en && (&w_elig) && (&w_req_half) && (w_req_signed[0] == w_req_signed[1]);
        w_grant = 2'b00;
        if (w_pack) begin
            w_grant = 2'b11;
        end else if (!r_ptr) begin
            if (w_elig[0])      w_grant = 2'b01;
            else if (w_elig[1]) w_grant = 2'b10;
        end else begin
            if (w_elig[1])      w_grant = 2'b10;
            else if (w_elig[0]) w_grant = 2'b01;
        end
    end

    assign w_sel = w_grant[1];

    always_comb begin
        w_issue_mode = MODE_IDLE;
        w_mul_a      = '0;
        w_mul_b      = '0;
        w_mul_a_sign = 1'b0;
        w_mul_b_sign = 1'b0;
        if (w_pack) begin
            w_issue_mode = MODE_HALF;
            w_mul_a      = {req1_a[HALF_W-1:0], req0_a[HALF_W-1:0]};
            w_mul_b      = {req1_b[HALF_W-1:0], req0_b[HALF_W-1:0]};
            w_mul_a_sign = req0_signed;
            w_mul_b_sign = req0_signed;
        end else if (w_grant != 2'b00) begin
            w_mul_a_sign = w_req_signed[w_sel];
            w_mul_b_sign = w_req_signed[w_sel];
            if (w_req_half[w_sel]) begin
                w_issue_mode = MODE_HALF;
                w_mul_a      = {{(LANE_W-HALF_W){1'b0}}, w_req_a[w_sel][HALF_W-1:0]};
                w_mul_b      = {{(LANE_W-HALF_W){1'b0}}, w_req_b[w_sel][HALF_W-1:0]};
            end else begin
                w_issue_mode = MODE_FULL;
                w_mul_a      = w_req_a[w_sel];
                w_mul_b      = w_req_b[w_sel];
            end
        end
    end

    assign w_half_0 = (w_issue_mode != MODE_HALF);
    assign w_half_1 = (w_issue_mode == MODE_HALF);

    multiplier_S_C2x2_F1_8bits_8bits_HighLevelDescribed_auto u_mult (
        .i_a      (w_mul_a),
        .i_b      (w_mul_b),
        .i_a_sign (w_mul_a_sign),
        .i_b_sign (w_mul_b_sign),
        .i_half_0 (w_half_0),
        .i_half_1 (w_half_1),
        .o_c      (w_mul_c)
    );

    generate
        for (gi = 0; gi < 2; gi++) begin : g_res
            logic              r_res_valid;
            logic [PROD_W-1:0] r_res_c;
            logic [LANE_W-1:0] w_lane;
            logic [PROD_W-1:0] w_res_next;

            // Only requester 1 of a packed pair reads the upper lane; single half ops use the lower.
            assign w_lane     = (w_pack && gi == 1) ? w_mul_c[PROD_W-1:LANE_W] : w_mul_c[LANE_W-1:0];
            assign w_res_next = w_req_half[gi] ? ext_lane(w_lane, w_req_signed[gi]) : w_mul_c;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_res_valid <= 1'b0;
                    r_res_c     <= '0;
                end else if (w_grant[gi]) begin
                    r_res_valid <= 1'b1;
                    r_res_c     <= w_res_next;
                end else if (w_res_ready[gi]) begin
                    r_res_valid <= 1'b0;
                end
            end

            assign w_res_valid[gi] = r_res_valid;
            assign w_res_q[gi]     = r_res_c;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= 1'b0;
            r_pack_cnt <= '0;
        end else if (w_pack) begin
            r_pack_cnt <= r_pack_cnt + 16'd1;
        end else if (w_grant == 2'b01) begin
            r_ptr <= 1'b1;
        end else if (w_grant == 2'b10) begin
            r_ptr <= 1'b0;
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign res0_valid = w_res_valid[0];
    assign res1_valid = w_res_valid[1];
    assign res0_c     = w_res_q[0];
    assign res1_c     = w_res_q[1];
    assign pack_cnt   = r_pack_cnt;

endmodule

// File: tb/tb_mult_pack_scheduler.sv
// Directed-vector bench for mult_pack_scheduler with hand-computed expected results.
module tb_mult_pack_scheduler;

    logic        clk;
    logic        rst_n;
    logic        pack_en_ovr;
    logic        pack_en;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_signed, req0_half, req1_signed, req1_half;
    logic        res0_valid, res1_valid;
    logic        res0_ready, res1_ready;
    logic [15:0] res0_c, res1_c;
    logic [15:0] pack_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    mult_pack_scheduler #(.PACK_DEFAULT(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pack_en_ovr (pack_en_ovr),
        .pack_en     (pack_en),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_signed (req0_signed),
        .req0_half   (req0_half),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_signed (req1_signed),
        .req1_half   (req1_half),
        .res0_valid  (res0_valid),
        .res0_ready  (res0_ready),
        .res0_c      (res0_c),
        .res1_valid  (res1_valid),
        .res1_ready  (res1_ready),
        .res1_c      (res1_c),
        .pack_cnt    (pack_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s: got %h", tag, obs);
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic h);
        req0_valid = v; req0_a = a; req0_b = b; req0_signed = s; req0_half = h;
    endtask

    task automatic drive1(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic h);
        req1_valid = v; req1_a = a; req1_b = b; req1_signed = s; req1_half = h;
    endtask

    initial begin
        rst_n = 1'b0; pack_en_ovr = 1'b1; pack_en = 1'b1;
        res0_ready = 1'b1; res1_ready = 1'b1;
        drive0(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        drive1(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        #1;
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        step();
        check("rst_res0_valid", {31'd0, res0_valid}, 32'd0);
        check("rst_res1_valid", {31'd0, res1_valid}, 32'd0);
        check("rst_pack_cnt", {16'd0, pack_cnt}, 32'd0);

        // Full signed 8x8: -10 * 7 = -70.
        rst_n = 1'b1;
        drive0(1'b1, 8'hF6, 8'h07, 1'b1, 1'b0);
        drive1(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        check("full_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("full_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("full_res0_valid", {31'd0, res0_valid}, 32'd1);
        check("full_res0_c", {16'd0, res0_c}, 32'h0000FFBA);
        step();
        check("drain_res0_valid", {31'd0, res0_valid}, 32'd0);

        // Packed signed pair: -7*3 = -21 lower lane, 5*-2 = -10 upper lane.
        drive0(1'b1, 8'h09, 8'h03, 1'b1, 1'b1);
        drive1(1'b1, 8'h05, 8'h0E, 1'b1, 1'b1);
        #1;
        check("pack_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("pack_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive1(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("pack_res0_c", {16'd0, res0_c}, 32'h0000FFEB);
        check("pack_res1_c", {16'd0, res1_c}, 32'h0000FFF6);
        check("pack_cnt_1", {16'd0, pack_cnt}, 32'd1);

        // Single req1 grant (unsigned 3*4) returns the pointer to requester 0.
        drive1(1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
        #1;
        check("r1_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        drive1(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("r1_res1_c", {16'd0, res1_c}, 32'h0000000C);

        // Mixed signedness cannot pack: serialize req0 (-1*3) then req1 (15*15 unsigned).
        drive0(1'b1, 8'h0F, 8'h03, 1'b1, 1'b1);
        drive1(1'b1, 8'h0F, 8'h0F, 1'b0, 1'b1);
        #1;
        check("mix_c0_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("mix_c0_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("mix_res0_c", {16'd0, res0_c}, 32'h0000FFFD);
        #1;
        check("mix_c1_req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        drive1(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("mix_res1_c", {16'd0, res1_c}, 32'h000000E1);
        check("mix_pack_cnt", {16'd0, pack_cnt}, 32'd1);

        // Backpressure on res0: slot holds while req1 keeps being served.
        drive0(1'b1, 8'd10, 8'd10, 1'b0, 1'b0);
        #1;
        check("bp_fill_ready", {31'd0, req0_ready}, 32'd1);
        step();
        res0_ready = 1'b0;
        drive0(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
        check("bp_fill_c", {16'd0, res0_c}, 32'h00000064);
        for (int i = 0; i < 3; i++) begin
            drive1(1'b1, 8'(i + 2), 8'd5, 1'b0, 1'b0);
            #1;
            check($sformatf("bp%0d_req0_ready", i), {31'd0, req0_ready}, 32'd0);
            check($sformatf("bp%0d_req1_ready", i), {31'd0, req1_ready}, 32'd1);
            step();
            check($sformatf("bp%0d_res0_valid", i), {31'd0, res0_valid}, 32'd1);
            check($sformatf("bp%0d_res0_c", i), {16'd0, res0_c}, 32'h00000064);
            check($sformatf("bp%0d_res1_c", i), {16'd0, res1_c}, 32'((i + 2) * 5));
        end
        // Releasing the slot with req0 still valid refills it the same cycle.
        drive1(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        res0_ready = 1'b1;
        #1;
        check("refill_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("refill_res0_valid", {31'd0, res0_valid}, 32'd1);
        check("refill_res0_c", {16'd0, res0_c}, 32'h00000004);
        step();
        check("refill_drain", {31'd0, res0_valid}, 32'd0);

        // Unsigned full corner: 255*255.
        drive0(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        step();
        drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("ufull_res0_c", {16'd0, res0_c}, 32'h0000FE01);

        // Long packing run via PACK_DEFAULT (override off, pack_en low) to reach the counter wrap.
        pack_en_ovr = 1'b0; pack_en = 1'b0;
        drive0(1'b1, 8'h07, 8'h09, 1'b0, 1'b1);
        drive1(1'b1, 8'h0F, 8'h0F, 1'b0, 1'b1);
        #1;
        check("dflt_ready_both", {30'd0, req1_ready, req0_ready}, 32'd3);
        repeat (16'hFFFE) @(posedge clk);
        #1;
        check("wrap_pre_cnt", {16'd0, pack_cnt}, 32'h0000FFFF);
        check("wrap_res0_c", {16'd0, res0_c}, 32'h0000003F);
        check("wrap_res1_c", {16'd0, res1_c}, 32'h000000E1);
        step();
        check("wrap_cnt", {16'd0, pack_cnt}, 32'h00000000);

        // Override low enable: the same compatible pair is serialized instead.
        pack_en_ovr = 1'b1; pack_en = 1'b0;
        #1;
        check("ovr_one_ready", {30'd0, req1_ready, req0_ready} == 32'd1 ||
                               {30'd0, req1_ready, req0_ready} == 32'd2, 32'd1);
        step();
        check("ovr_cnt", {16'd0, pack_cnt}, 32'd0);
        drive1(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset while a result is held: clears slot and pointer.
        res0_ready = 1'b0;
        drive0(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
        step();
        step();
        check("prerst_res0_valid", {31'd0, res0_valid}, 32'd1);
        rst_n = 1'b0;
        drive1(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
        #1;
        check("inrst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("inrst_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        check("postrst_res0_valid", {31'd0, res0_valid}, 32'd0);
        check("postrst_res0_c", {16'd0, res0_c}, 32'd0);
        check("postrst_pack_cnt", {16'd0, pack_cnt}, 32'd0);
        rst_n = 1'b1;
        res0_ready = 1'b1;
        #1;
        check("postrst_ptr_req0", {31'd0, req0_ready}, 32'd1);
        check("postrst_ptr_req1", {31'd0, req1_ready}, 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_pack_scheduler.md
MULT_PACK_SCHEDULER -- requirements
Module: mult_pack_scheduler

Interface
REQ-001 SHALL have parameter PACK_DEFAULT, default 1, reset value of the internal packing enable when pack_en_ovr is low.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port pack_en_ovr  input  1  when high, pack_en input replaces PACK_DEFAULT.
REQ-005 SHALL have port pack_en  input  1  lane-packing enable (used when pack_en_ovr=1).
REQ-006 SHALL have ports reqN_valid  input  1, reqN_ready  output  1  request handshake, N in {0,1}.
REQ-007 SHALL have ports reqN_a, reqN_b  input  8  operands (4-bit ops use [3:0]).
REQ-008 SHALL have ports reqN_signed  input  1 (two's-complement operands) and reqN_half  input  1 (4x4 op).
REQ-009 SHALL have ports resN_valid  output  1, resN_ready  input  1, resN_c  output  16  result handshake/data.
REQ-010 SHALL have port pack_cnt  output  16  count of packed issues, wraps 16'hFFFF->0.

Function
REQ-011 SHALL share one precision-configurable 8x8 / dual-4x4 multiplier between two requesters; a request transfers when reqN_valid && reqN_ready.
REQ-012 SHALL define requester N eligible when reqN_valid && (!resN_valid || resN_ready).
REQ-013 SHALL pack when effective pack_en=1, both eligible, both half=1, req0_signed==req1_signed: both ready the same cycle; req0 in lower lane (A[3:0],B[3:0]->C[7:0]), req1 in upper lane (A[7:4],B[7:4]->C[15:8]); HALF_0=0, HALF_1=1, A_sign=B_sign=shared signed.
REQ-014 SHALL otherwise grant at most one eligible requester by round-robin: pointer ptr selects first choice; other granted only if ptr's requester ineligible.
REQ-015 SHALL issue a single full op with HALF_0=1, HALF_1=0, A=reqN_a, B=reqN_b, signs=reqN_signed.
REQ-016 SHALL issue a single half op in lower lane, HALF_0=0, HALF_1=1, upper nibbles 0, result from C[7:0].
REQ-017 SHALL drive the multiplier idle (HALF_0=1, HALF_1=0, A=B=0, signs 0) when nothing granted.
REQ-018 SHALL set ptr to the other requester after a single grant; SHALL leave ptr unchanged after a packed or no grant.
REQ-019 SHALL register results: grant in cycle N -> resN_valid=1 and resN_c valid in cycle N+1 (latency 1).
REQ-020 SHALL sign-extend (signed) or zero-extend (unsigned) 8-bit lane products to 16 bits for resN_c.
REQ-021 SHALL hold resN_valid and resN_c stable while resN_ready=0; clear resN_valid on resN_ready unless a new grant refills the slot the same cycle.
REQ-022 SHALL make reqN_ready combinational from grant only, never dependent on reqN_ready's own feedback; reqN_ready=0 while rst_n=0.
REQ-023 SHALL increment pack_cnt by 1 per packed issue, wrapping at 16 bits.

Reset
REQ-024 SHALL, on a rising clk with rst_n=0, clear resN_valid, resN_c=16'h0, ptr=0, pack_cnt=0, discarding any in-flight result.
REQ-025 SHALL hold reqN_ready=0 and grant nothing in any cycle with rst_n=0.

Structure
REQ-026 SHALL place lane-width constants (8, 4), product width 16 and the mode encoding (FULL, HALF, IDLE) in shared package mult_sched_pkg.
REQ-027 SHALL instantiate exactly one sub-module, multiplier_S_C2x2_F1_8bits_8bits_HighLevelDescribed_auto, combinationally in the issue stage.

Verification
REQ-028 SHALL cover: req0 full signed a=8'hF6, b=8'h07 -> req0_ready same cycle, next cycle res0_valid=1, res0_c=16'hFFBA.
REQ-029 SHALL cover: pack_en=1, req0 half signed a=4'h9,b=4'h3 and req1 half signed a=4'h5,b=4'hE together -> both ready same cycle; next cycle res0_c=16'hFFEB, res1_c=16'hFFF6, pack_cnt=1.
REQ-030 SHALL cover: both half, req0 signed, req1 unsigned, ptr=0 -> req0 granted cycle 0, req1 cycle 1, pack_cnt unchanged.
REQ-031 SHALL cover: res0_valid=1 with res0_ready=0 for 3 cycles, req0 and req1 valid -> req0_ready=0, res0_c stable, req1 served each cycle.
REQ-032 SHALL cover: unsigned full 8'hFF x 8'hFF -> res_c=16'hFE01; pack_cnt preloaded to 16'hFFFF then one pack -> 16'h0000.
REQ-033 SHALL cover: rst_n=0 one cycle while res0_valid=1 -> next cycle res0_valid=0, res0_c=0, ptr=0, req ready low during reset.
